axi_mem_tester: RTL and testbench

Parametrised AXI DDR read/write self-test engine, the successor to the fixed 256-bit single-pattern checker. It writes a selectable data pattern over an address range in INCR bursts, then reads the range back and compares it. It adds error counting, first-failure capture, response/rlast checking, a loop mode with per-pass inversion, and graceful stop. It sits between the test-control/status registers and one AXI port of the DDR controller, using the shared address channel with atype.

---
 rtl/axi_mem_tester_pkg.sv | 25 ++
 rtl/axi_mem_pattern_gen.sv | 40 ++++
 rtl/axi_mem_tester.sv | 268 ++++++++++++++++++++++++++
 tb/tb_axi_mem_tester.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_mem_tester_pkg.sv
// Shared encodings for the AXI memory self-test engine: FSM states, pattern modes and AXI
// constants.
package axi_mem_tester_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WR_ADDR = 3'd1;
  localparam logic [2:0] ST_WR_DATA = 3'd2;
  localparam logic [2:0] ST_WR_RESP = 3'd3;
  localparam logic [2:0] ST_RD_ADDR = 3'd4;
  localparam logic [2:0] ST_RD_DATA = 3'd5;
  localparam logic [2:0] ST_NEXT    = 3'd6;
  localparam logic [2:0] ST_DONE    = 3'd7;

  localparam logic [1:0] MODE_ADDR     = 2'd0;
  localparam logic [1:0] MODE_INV_ADDR = 2'd1;
  localparam logic [1:0] MODE_WALK1    = 2'd2;
  localparam logic [1:0] MODE_HASH     = 2'd3;

  localparam logic [31:0] HASH_MULT = 32'h9E37_79B1;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] LOCK_NORMAL = 2'b00;
  localparam logic [1:0] RESP_OKAY   = 2'b00;

endpackage

// File: rtl/axi_mem_pattern_gen.sv
// Combinational test-pattern generator: maps a beat byte address, mode and pass parity to
// one full data word, built lane by lane (32 bits per lane).
module axi_mem_pattern_gen
  import axi_mem_tester_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 256
) (
  input  logic [31:0]           addr,
  input  logic [1:0]            mode,
  input  logic                  invert,
  output logic [DATA_WIDTH-1:0] data
);

  localparam int unsigned LANES = DATA_WIDTH / 32;
  localparam int unsigned ASIZE = $clog2(DATA_WIDTH / 8);

  logic [31:0] word_idx;
  assign word_idx = addr >> ASIZE;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [31:0] lane_addr;
    logic [4:0]  walk_sh;
    logic [31:0] lane_val;

    assign lane_addr = addr + 32'(4 * k);
    assign walk_sh   = 5'(word_idx + 32'(k));

    always_comb begin
      unique case (mode)
        MODE_ADDR:     lane_val = lane_addr;
        MODE_INV_ADDR: lane_val = ~lane_addr;
        MODE_WALK1:    lane_val = 32'd1 << walk_sh;
        MODE_HASH:     lane_val = lane_addr * HASH_MULT;
      endcase
    end

    assign data[k*32 +: 32] = lane_val ^ {32{invert}};
  end

endmodule

// File: rtl/axi_mem_tester.sv
// AXI DDR self-test engine: writes a pattern over [START_ADDR, STOP_ADDR) in INCR bursts,
// reads it back and compares, with error counting, first-failure capture and loop mode.
module axi_mem_tester
  import axi_mem_tester_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 256,
  parameter int unsigned ALEN       = 15,
  parameter logic [31:0] START_ADDR = 32'h0000_0000,
  parameter logic [31:0] STOP_ADDR  = 32'h0010_0000,
  parameter int unsigned ERR_CNT_W  = 16
) (
  input  logic                    axi_clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [1:0]              mode,
  input  logic                    loop_en,
  input  logic                    stop,
  output logic [7:0]              aid,
  output logic [7:0]              wid,
  output logic [31:0]             aaddr,
  output logic [7:0]              alen,
  output logic [2:0]              asize,
  output logic [1:0]              aburst,
  output logic [1:0]              alock,
  output logic                    atype,
  output logic                    avalid,
  input  logic                    aready,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    wlast,
  output logic                    wvalid,
  input  logic                    wready,
  input  logic                    bvalid,
  input  logic [1:0]              bresp,
  output logic                    bready,
  input  logic [DATA_WIDTH-1:0]   rdata,
  input  logic [1:0]              rresp,
  input  logic                    rlast,
  input  logic                    rvalid,
  output logic                    rready,
  output logic                    busy,
  output logic                    done,
  output logic                    fail,
  output logic [ERR_CNT_W-1:0]    err_count,
  output logic [15:0]             pass_count,
  output logic [31:0]             first_fail_addr,
  output logic [DATA_WIDTH-1:0]   first_fail_exp,
  output logic [DATA_WIDTH-1:0]   first_fail_det,
  output logic [3:0]              states
);

  localparam int unsigned BYTES       = DATA_WIDTH / 8;
  localparam int unsigned ASIZE       = $clog2(BYTES);
  localparam logic [31:0] BURST_BYTES = 32'((ALEN + 1) * BYTES);
  localparam logic [7:0]  LAST_BEAT   = 8'(ALEN);

  logic [2:0]            state_q, state_d;
  logic [31:0]           addr_q, addr_d;
  logic [7:0]            wr_beat_q, wr_beat_d;
  logic [7:0]            rd_beat_q, rd_beat_d;
  logic [1:0]            mode_q, mode_d;
  logic                  invert_q, invert_d;
  logic                  stop_seen_q, stop_seen_d;
  logic [ERR_CNT_W-1:0]  err_count_q, err_count_d;
  logic [15:0]           pass_count_q, pass_count_d;
  logic                  ff_valid_q, ff_valid_d;
  logic [31:0]           ff_addr_q, ff_addr_d;
  logic [DATA_WIDTH-1:0] ff_exp_q, ff_exp_d;
  logic [DATA_WIDTH-1:0] ff_det_q, ff_det_d;
  logic                  start_meta_q, start_sync_q, start_prev_q;

  logic                  launch, stop_flag, rd_bad, err_event;
  logic [31:0]           next_addr, wr_addr, rd_addr, err_addr;
  logic [DATA_WIDTH-1:0] wr_pat, rd_pat, err_exp, err_det;

  assign wr_addr = addr_q + (32'(wr_beat_q) << ASIZE);
  assign rd_addr = addr_q + (32'(rd_beat_q) << ASIZE);

  axi_mem_pattern_gen #(.DATA_WIDTH(DATA_WIDTH)) u_wr_pat (
    .addr  (wr_addr),
    .mode  (mode_q),
    .invert(invert_q),
    .data  (wr_pat)
  );

  axi_mem_pattern_gen #(.DATA_WIDTH(DATA_WIDTH)) u_rd_pat (
    .addr  (rd_addr),
    .mode  (mode_q),
    .invert(invert_q),
    .data  (rd_pat)
  );

  assign launch    = start_sync_q & ~start_prev_q;
  assign stop_flag = stop_seen_q | stop;
  assign next_addr = addr_q + BURST_BYTES;
  assign rd_bad    = (rdata != rd_pat) || (rresp != RESP_OKAY) ||
                     (rlast != (rd_beat_q == LAST_BEAT));

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wr_beat_d    = wr_beat_q;
    rd_beat_d    = rd_beat_q;
    mode_d       = mode_q;
    invert_d     = invert_q;
    stop_seen_d  = stop_seen_q | (busy & stop);
    err_count_d  = err_count_q;
    pass_count_d = pass_count_q;
    ff_valid_d   = ff_valid_q;
    ff_addr_d    = ff_addr_q;
    ff_exp_d     = ff_exp_q;
    ff_det_d     = ff_det_q;
    err_event    = 1'b0;
    err_addr     = rd_addr;
    err_exp      = rd_pat;
    err_det      = rdata;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (launch) begin
          state_d      = ST_WR_ADDR;
          addr_d       = START_ADDR;
          mode_d       = mode;
          invert_d     = 1'b0;
          stop_seen_d  = 1'b0;
          err_count_d  = '0;
          pass_count_d = '0;
          ff_valid_d   = 1'b0;
          ff_addr_d    = '0;
          ff_exp_d     = '0;
          ff_det_d     = '0;
        end
      end
      ST_WR_ADDR: begin
        if (aready) begin
          state_d   = ST_WR_DATA;
          wr_beat_d = '0;
        end
      end
      ST_WR_DATA: begin
        if (wready) begin
          if (wr_beat_q == LAST_BEAT) state_d = ST_WR_RESP;
          else wr_beat_d = wr_beat_q + 8'd1;
        end
      end
      ST_WR_RESP: begin
        if (bvalid) begin
          // A bad write response has no data to show; capture only its burst address.
          err_event = (bresp != RESP_OKAY);
          err_addr  = addr_q;
          err_exp   = '0;
          err_det   = '0;
          if (next_addr < STOP_ADDR) begin
            addr_d  = next_addr;
            state_d = stop_flag ? ST_DONE : ST_WR_ADDR;
          end else begin
            addr_d  = START_ADDR;
            state_d = stop_flag ? ST_DONE : ST_RD_ADDR;
          end
        end
      end
      ST_RD_ADDR: begin
        if (aready) begin
          state_d   = ST_RD_DATA;
          rd_beat_d = '0;
        end
      end
      ST_RD_DATA: begin
        if (rvalid) begin
          err_event = rd_bad;
          // Burst end follows the beat count, so an early rlast is flagged but not obeyed.
          if (rd_beat_q == LAST_BEAT) state_d = ST_NEXT;
          else rd_beat_d = rd_beat_q + 8'd1;
        end
      end
      ST_NEXT: begin
        if (next_addr < STOP_ADDR) begin
          addr_d  = next_addr;
          state_d = stop_flag ? ST_DONE : ST_RD_ADDR;
        end else begin
          pass_count_d = pass_count_q + 16'd1;
          if (loop_en && !stop_flag) begin
            invert_d = ~invert_q;
            addr_d   = START_ADDR;
            state_d  = ST_WR_ADDR;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (err_event) begin
      if (err_count_q != {ERR_CNT_W{1'b1}}) err_count_d = err_count_q + ERR_CNT_W'(1);
      if (!ff_valid_q) begin
        ff_valid_d = 1'b1;
        ff_addr_d  = err_addr;
        ff_exp_d   = err_exp;
        ff_det_d   = err_det;
      end
    end
  end

  always_ff @(posedge axi_clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      wr_beat_q    <= '0;
      rd_beat_q    <= '0;
      mode_q       <= '0;
      invert_q     <= 1'b0;
      stop_seen_q  <= 1'b0;
      err_count_q  <= '0;
      pass_count_q <= '0;
      ff_valid_q   <= 1'b0;
      ff_addr_q    <= '0;
      ff_exp_q     <= '0;
      ff_det_q     <= '0;
      start_meta_q <= 1'b0;
      start_sync_q <= 1'b0;
      start_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wr_beat_q    <= wr_beat_d;
      rd_beat_q    <= rd_beat_d;
      mode_q       <= mode_d;
      invert_q     <= invert_d;
      stop_seen_q  <= stop_seen_d;
      err_count_q  <= err_count_d;
      pass_count_q <= pass_count_d;
      ff_valid_q   <= ff_valid_d;
      ff_addr_q    <= ff_addr_d;
      ff_exp_q     <= ff_exp_d;
      ff_det_q     <= ff_det_d;
      start_meta_q <= start;
      start_sync_q <= start_meta_q;
      start_prev_q <= start_sync_q;
    end
  end

  assign aid             = 8'd0;
  assign wid             = 8'd0;
  assign alen            = LAST_BEAT;
  assign asize           = 3'(ASIZE);
  assign aburst          = BURST_INCR;
  assign alock           = LOCK_NORMAL;
  assign wstrb           = '1;
  assign aaddr           = addr_q;
  assign avalid          = (state_q == ST_WR_ADDR) || (state_q == ST_RD_ADDR);
  assign atype           = (state_q == ST_WR_ADDR);
  assign wvalid          = (state_q == ST_WR_DATA);
  assign wdata           = wvalid ? wr_pat : '0;
  assign wlast           = wvalid && (wr_beat_q == LAST_BEAT);
  assign bready          = (state_q == ST_WR_RESP);
  assign rready          = (state_q == ST_RD_DATA);
  assign busy            = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done            = (state_q == ST_DONE);
  assign fail            = |err_count_q;
  assign err_count       = err_count_q;
  assign pass_count      = pass_count_q;
  assign first_fail_addr = ff_addr_q;
  assign first_fail_exp  = ff_exp_q;
  assign first_fail_det  = ff_det_q;
  assign states          = {1'b0, state_q};

endmodule

// File: tb/tb_axi_mem_tester.sv
// Bench for axi_mem_tester: a small AXI slave with memory and fault injection, plus a
// scoreboard of expected address-channel transactions and write beats.
module tb_axi_mem_tester;

  localparam int DW = 256;

  logic            axi_clk = 1'b0;
  logic            rst, start, loop_en, stop;
  logic [1:0]      mode;
  logic [7:0]      aid, wid, alen;
  logic [31:0]     aaddr, first_fail_addr;
  logic [2:0]      asize;
  logic [1:0]      aburst, alock, bresp, rresp;
  logic            atype, avalid, aready, wlast, wvalid, wready, bvalid, bready;
  logic            rlast, rvalid, rready, busy, done, fail;
  logic [DW-1:0]   wdata, rdata, first_fail_exp, first_fail_det;
  logic [DW/8-1:0] wstrb;
  logic [15:0]     err_count, pass_count;
  logic [3:0]      states;

  always #5 axi_clk = ~axi_clk;

  axi_mem_tester #(
    .DATA_WIDTH(DW), .ALEN(3), .START_ADDR(32'h0), .STOP_ADDR(32'h200), .ERR_CNT_W(16)
  ) dut (
    .axi_clk(axi_clk), .rst(rst), .start(start), .mode(mode), .loop_en(loop_en),
    .stop(stop), .aid(aid), .wid(wid), .aaddr(aaddr), .alen(alen), .asize(asize),
    .aburst(aburst), .alock(alock), .atype(atype), .avalid(avalid), .aready(aready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bresp(bresp), .bready(bready), .rdata(rdata), .rresp(rresp),
    .rlast(rlast), .rvalid(rvalid), .rready(rready), .busy(busy), .done(done),
    .fail(fail), .err_count(err_count), .pass_count(pass_count),
    .first_fail_addr(first_fail_addr), .first_fail_exp(first_fail_exp),
    .first_fail_det(first_fail_det), .states(states)
  );

  typedef struct {
    logic [31:0] addr;
    logic        wr;
  } a_exp_t;

  a_exp_t        exp_a[$];
  logic [DW-1:0] exp_w[$];
  logic [DW-1:0] mem[logic [31:0]];
  logic [DW-1:0] first_wr[logic [31:0]];
  logic [31:0]   r_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int a_cnt, w_cnt, r_cnt, rd_bursts;
  int ideal_a, ideal_w, ideal_r;

  // Slave-side configuration and fault injection
  logic        bp = 1'b0;
  logic        b_err_once;
  logic [31:0] flip_addr, rresp_addr, rlast_addr;

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] model(input logic [31:0] w, input logic [1:0] m,
                                          input logic inv);
    logic [31:0] l, v;
    model = '0;
    for (int k = 0; k < 8; k++) begin
      l = w + 32'(4 * k);
      case (m)
        2'd0:    v = l;
        2'd1:    v = ~l;
        2'd2:    v = 32'd1 << ((w / 32 + 32'(k)) % 32);
        default: v = l * 32'h9E37_79B1;
      endcase
      model[k*32 +: 32] = v ^ {32{inv}};
    end
  endfunction

  task automatic cyc();
    @(posedge axi_clk);
    #1;
  endtask

  task automatic clear_model();
    mem.delete();
    first_wr.delete();
    exp_a.delete();
    exp_w.delete();
    b_err_once = 1'b0;
    flip_addr  = 32'hFFFF_FFFF;
    rresp_addr = 32'hFFFF_FFFF;
    rlast_addr = 32'hFFFF_FFFF;
  endtask

  task automatic push_pass(input logic [1:0] m, input logic inv, input int nrd);
    for (int b = 0; b < 4; b++) begin
      exp_a.push_back('{addr: 32'(b * 128), wr: 1'b1});
      for (int t = 0; t < 4; t++) exp_w.push_back(model(32'(b * 128 + t * 32), m, inv));
    end
    for (int b = 0; b < nrd; b++) exp_a.push_back('{addr: 32'(b * 128), wr: 1'b0});
  endtask

  task automatic launch(input logic [1:0] m, input logic lp);
    int n = 0;
    mode = m;
    loop_en = lp;
    a_cnt = 0; w_cnt = 0; r_cnt = 0; rd_bursts = 0;
    start = 1'b1;
    while (!busy && n < 10) begin cyc(); n++; end
    check_eq("launch_busy", 256'(busy), 256'(1));
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 5000) begin cyc(); n++; end
    check_eq("done", 256'(done), 256'(1));
    check_eq("a_left", 256'(exp_a.size()), 256'(0));
    check_eq("w_left", 256'(exp_w.size()), 256'(0));
  endtask

  // AXI slave: decides ready/valid each cycle just after the edge; a handshake seen here
  // completes at the next edge, so it is accounted for immediately.
  initial begin : slave
    int          w_beat, r_beat;
    logic [31:0] w_base, ra, a_prev;
    logic        b_pend, a_stall, w_stall;
    logic [DW-1:0] w_prev, ew;
    a_exp_t      ea;
    aready = 0; wready = 0; bvalid = 0; bresp = 0;
    rvalid = 0; rdata = '0; rresp = 0; rlast = 0;
    w_beat = 0; r_beat = 0; w_base = 0; b_pend = 0;
    a_stall = 0; w_stall = 0; a_prev = 0; w_prev = '0;
    forever begin
      cyc();
      if (rst) begin
        aready = 0; wready = 0; bvalid = 0; rvalid = 0; rlast = 0;
        r_q.delete();
        w_beat = 0; r_beat = 0; b_pend = 0; a_stall = 0; w_stall = 0;
        continue;
      end
      if (a_stall) check_eq("a_hold", 256'({avalid, aaddr}), 256'({1'b1, a_prev}));
      if (w_stall) check_eq("w_hold", {wdata[DW-2:0], wvalid}, {w_prev[DW-2:0], 1'b1});

      bvalid = b_pend;
      bresp  = (b_pend && b_err_once) ? 2'b10 : 2'b00;
      if (bvalid && bready) begin
        b_pend = 0;
        b_err_once = 1'b0;
      end

      if (r_q.size() > 0) begin
        rvalid = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        ra     = r_q[0] + 32'(r_beat * 32);
        rdata  = mem.exists(ra) ? mem[ra] : '0;
        if (ra == flip_addr) rdata[0] = ~rdata[0];
        rresp  = (ra == rresp_addr) ? 2'b10 : 2'b00;
        rlast  = (r_beat == 3) || (ra == rlast_addr);
        if (rvalid && rready) begin
          r_cnt++;
          r_beat++;
          if (r_beat == 4) begin
            r_beat = 0;
            void'(r_q.pop_front());
          end
        end
      end else begin
        rvalid = 0;
        rlast  = 0;
      end

      wready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (wvalid && wready) begin
        ew = (exp_w.size() > 0) ? exp_w.pop_front() : '1;
        check_eq("wdata", wdata, ew);
        check_eq("wlast", 256'(wlast), 256'(w_beat == 3));
        ra = w_base + 32'(w_beat * 32);
        if (!first_wr.exists(ra)) first_wr[ra] = wdata;
        mem[ra] = wdata;
        w_cnt++;
        w_beat++;
        if (w_beat == 4) begin
          w_beat = 0;
          b_pend = 1;
        end
      end

      aready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (avalid && aready) begin
        ea = (exp_a.size() > 0) ? exp_a.pop_front() : '{addr: 32'hDEAD_BEEF, wr: 1'b0};
        check_eq("aaddr", 256'(aaddr), 256'(ea.addr));
        check_eq("atype", 256'(atype), 256'(ea.wr));
        check_eq("aconst", 256'({alen, asize, aburst, alock}), 256'({8'd3, 3'd5, 2'b01, 2'b00}));
        a_cnt++;
        if (atype) begin
          w_base = aaddr;
          w_beat = 0;
        end else begin
          r_q.push_back(aaddr);
          rd_bursts++;
        end
      end
      a_stall = avalid && !aready;
      a_prev  = aaddr;
      w_stall = wvalid && !wready;
      w_prev  = wdata;
    end
  end

  initial begin : main
    int n;
    rst = 1'b1; start = 1'b0; mode = 2'd0; loop_en = 1'b0; stop = 1'b0;
    clear_model();
    repeat (3) cyc();
    check_eq("rst_ctrl", 256'({busy, done, fail, avalid, wvalid, bready, rready, wlast, atype}),
             256'(0));
    check_eq("rst_state", 256'(states), 256'(0));
    check_eq("rst_const", 256'({aid, wid, alen, asize, aburst, alock}),
             256'({8'd0, 8'd0, 8'd3, 3'd5, 2'b01, 2'b00}));
    check_eq("rst_wstrb", 256'(wstrb), 256'(32'hFFFF_FFFF));
    check_eq("rst_cnt", 256'({err_count, pass_count, first_fail_addr, aaddr}), 256'(0));
    check_eq("rst_wdata", wdata, '0);
    rst = 1'b0;
    cyc();

    // Ideal run, mode ADDR
    clear_model();
    push_pass(2'd0, 1'b0, 4);
    launch(2'd0, 1'b0);
    wait_done();
    check_eq("t1_status", 256'({fail, err_count, pass_count}), 256'({1'b0, 16'd0, 16'd1}));
    check_eq("t1_lane0", 256'(mem[32'h20][31:0]), 256'(32'h20));
    check_eq("t1_lane7", 256'(mem[32'h20][255:224]), 256'(32'h3C));
    check_eq("t1_counts", 256'({a_cnt, w_cnt, r_cnt}), 256'({32'd8, 32'd16, 32'd16}));
    ideal_a = a_cnt; ideal_w = w_cnt; ideal_r = r_cnt;

    // Single bit flip on readback at 0xC0
    clear_model();
    flip_addr = 32'hC0;
    push_pass(2'd0, 1'b0, 4);
    launch(2'd0, 1'b0);
    wait_done();
    check_eq("t2_err", 256'({fail, err_count}), 256'({1'b1, 16'd1}));
    check_eq("t2_ffaddr", 256'(first_fail_addr), 256'(32'hC0));
    check_eq("t2_ffexp", 256'(first_fail_exp[31:0]), 256'(32'hC0));
    check_eq("t2_ffdet", 256'(first_fail_det[31:0]), 256'(32'hC1));

    // Bad rresp at 0x140, early rlast at 0x1A0
    clear_model();
    rresp_addr = 32'h140;
    rlast_addr = 32'h1A0;
    push_pass(2'd0, 1'b0, 4);
    launch(2'd0, 1'b0);
    wait_done();
    check_eq("t3_err", 256'(err_count), 256'(2));
    check_eq("t3_ffaddr", 256'(first_fail_addr), 256'(32'h140));

    // Loop mode HASH, stop during pass-2 read burst at 0x80
    clear_model();
    push_pass(2'd3, 1'b0, 4);
    push_pass(2'd3, 1'b1, 2);
    launch(2'd3, 1'b1);
    n = 0;
    while (rd_bursts < 6 && n < 2000) begin cyc(); n++; end
    check_eq("t4_reach", 256'(rd_bursts), 256'(6));
    stop = 1'b1;
    wait_done();
    stop = 1'b0;
    check_eq("t4_status", 256'({err_count, pass_count, states}), 256'({16'd0, 16'd1, 4'd7}));
    check_eq("t4_hash", 256'(first_wr[32'h20][31:0]), 256'(32'hC6EF_3620));
    check_eq("t4_p2_inv", mem[32'h0], ~first_wr[32'h0]);

    // Random back-pressure, mode WALK1
    clear_model();
    bp = 1'b1;
    push_pass(2'd2, 1'b0, 4);
    launch(2'd2, 1'b0);
    wait_done();
    bp = 1'b0;
    check_eq("t5_err", 256'({fail, err_count, pass_count}), 256'({1'b0, 16'd0, 16'd1}));
    check_eq("t5_counts", 256'({a_cnt, w_cnt, r_cnt}), 256'({ideal_a, ideal_w, ideal_r}));

    // Reset during a write burst after one bad bresp
    clear_model();
    b_err_once = 1'b1;
    push_pass(2'd1, 1'b0, 4);
    launch(2'd1, 1'b0);
    n = 0;
    while (!(err_count != 0 && states == 4'd2) && n < 300) begin cyc(); n++; end
    check_eq("t6_bresp", 256'({err_count, states}), 256'({16'd1, 4'd2}));
    rst = 1'b1;
    cyc();
    check_eq("t6_valids", 256'({avalid, wvalid, bready, rready}), 256'(0));
    check_eq("t6_state", 256'({states, err_count}), 256'(0));
    cyc();
    rst = 1'b0;
    clear_model();
    cyc();
    push_pass(2'd1, 1'b0, 4);
    launch(2'd1, 1'b0);
    wait_done();
    check_eq("t6_rerun", 256'({fail, err_count, pass_count}), 256'({1'b0, 16'd0, 16'd1}));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
